line_input_buffer: RTL and testbench

- Upstream feeder for the 5x5 bit-matrix encoder datapath.
- Accepts a serial bit stream and assembles it into LINE_W-bit lines, with row-major bit index i*5+j.
- Queues completed lines in a small FIFO.
- Presents each line to the encoder's line/init loading port with a valid/ready handshake, so the encoder controller pulls one line per encode pass.

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/line_input_buffer_if.sv | 35 +++
 rtl/line_fifo.sv | 93 +++++++++
 rtl/line_input_buffer.sv | 124 ++++++++++++
 tb/tb_line_input_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the 5x5 bit-matrix encoder datapath and its
// upstream line feeder.
//   MAT_DIM  - matrix edge length
//   LINE_W   - bits per line (MAT_DIM*MAT_DIM), row-major index i*MAT_DIM+j
//   CNT_W    - serial bit-counter width (2**CNT_W > LINE_W, parity bit included)
//   OCC_W    - width of FIFO occupancy counts (DEPTH up to 4)
//   line_t   - one full matrix line
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam int MAT_DIM = 5;
  localparam int LINE_W  = MAT_DIM * MAT_DIM;
  localparam int CNT_W   = 5;
  localparam int OCC_W   = 3;

  typedef logic [LINE_W-1:0] line_t;

  // Row-major position of matrix element (i, j) inside a line.
  function automatic int bit_index(input int i, input int j);
    return i * MAT_DIM + j;
  endfunction

endpackage

// File: rtl/line_input_buffer_if.sv
// -----------------------------------------------------------------------------
// line_input_buffer_if
// Bundles the serial bit input and the line output handshake of the
// line_input_buffer.
//   bit_in/bit_valid/bit_ready  serial bit stream, accepted on valid && ready
//   line/line_valid/line_ready  head-of-FIFO line towards the encoder
//   occupancy                   lines currently queued
//   parity_err                  one-cycle pulse when a line is dropped
// Modports: slave = the buffer, master = the feeder/encoder side.
// -----------------------------------------------------------------------------
interface line_input_buffer_if #(
  parameter int LINE_W = 25
);
  import encoder_pkg::OCC_W;

  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [LINE_W-1:0] line;
  logic              line_valid;
  logic              line_ready;
  logic [OCC_W-1:0]  occupancy;
  logic              parity_err;

  modport slave (
    input  bit_in, bit_valid, line_ready,
    output bit_ready, line, line_valid, occupancy, parity_err
  );

  modport master (
    output bit_in, bit_valid, line_ready,
    input  bit_ready, line, line_valid, occupancy, parity_err
  );

endinterface

// File: rtl/line_fifo.sv
// -----------------------------------------------------------------------------
// line_fifo
// LINE_W x DEPTH line queue with explicit occupancy counter and wrapping
// read/write pointers. Head entry is presented combinationally on pop_data.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        synchronous clear, overrides push and pop
//   push/push_data   write one line (ignored when full)
//   pop          drop the head line (ignored when empty)
//   pop_data     current head line
//   full/empty   registered status
//   occupancy    number of queued lines (0..DEPTH)
// -----------------------------------------------------------------------------
module line_fifo #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [LINE_W-1:0]             push_data,
  input  logic                          pop,
  output logic [LINE_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [encoder_pkg::OCC_W-1:0] occupancy
);
  import encoder_pkg::OCC_W;

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign occupancy = count_q;
  assign pop_data  = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the line output reads 0 until first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/line_input_buffer.sv
// -----------------------------------------------------------------------------
// line_input_buffer
// Assembles a serial bit stream into LINE_W-bit lines (first bit -> line[0],
// row-major i*5+j), queues completed lines in a DEPTH-entry FIFO and hands
// them to the encoder over a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   flush  synchronous clear of the partial line and the whole FIFO
//   bus    line_input_buffer_if.slave: bit_in/bit_valid/bit_ready,
//          line/line_valid/line_ready, occupancy, parity_err
// Build option: define LINE_PARITY_CHECK_EN to expect one even-parity bit
// after every line; a failing line is dropped and parity_err pulses once.
// Without it parity_err is tied to 0.
// -----------------------------------------------------------------------------
module line_input_buffer #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  line_input_buffer_if.slave  bus
);

`ifdef LINE_PARITY_CHECK_EN
  // The counter also covers the trailing parity bit.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_W);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_W - 1);
`endif

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] asm_q, asm_d;
  logic [LINE_W-1:0] full_line;
  logic              at_last;
  logic              accept;
  logic              push;
  logic              bit_ready_w;
  logic              fifo_full;
  logic              fifo_empty;

  assign at_last = (cnt_q == LAST_CNT);

  // Only registered FIFO state is used, so a pop in the same cycle cannot
  // open the door for the completing bit.
  assign bit_ready_w   = !(at_last && fifo_full);
  assign bus.bit_ready = bit_ready_w;
  assign accept        = bus.bit_valid && bit_ready_w;

  // Assembly register with the current bit merged in, so the completing bit
  // is pushed on the same edge it is accepted.
  always_comb begin
    full_line = asm_q;
    if (cnt_q < CNT_W'(LINE_W)) full_line[cnt_q] = bus.bit_in;
  end

`ifdef LINE_PARITY_CHECK_EN
  logic parity_ok;
  logic parity_err_q, parity_err_d;

  // Even parity over data plus parity bit.
  assign parity_ok    = ~^{asm_q, bus.bit_in};
  assign push         = accept && at_last && parity_ok && !flush;
  assign parity_err_d = accept && at_last && !parity_ok && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign push           = accept && at_last && !flush;
  assign bus.parity_err = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (flush) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (at_last) begin
        cnt_d = '0;
        asm_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = full_line;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  line_fifo #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (full_line),
    .pop       (bus.line_ready),
    .pop_data  (bus.line),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (bus.occupancy)
  );

  assign bus.line_valid = !fifo_empty;

endmodule

// File: tb/tb_line_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_input_buffer
// Directed test of line_input_buffer (DEPTH=2): reset state, line assembly,
// back-pressure when full, pop/push interaction, flush, mid-line reset and,
// when LINE_PARITY_CHECK_EN is defined, parity accept/drop.
// -----------------------------------------------------------------------------
module tb_line_input_buffer;

  localparam int LW = 25;
`ifdef LINE_PARITY_CHECK_EN
  localparam int NBITS = LW + 1;
`else
  localparam int NBITS = LW;
`endif

  localparam logic [LW-1:0] LINE_A = 25'h1555555;
  localparam logic [LW-1:0] LINE_B = 25'h0AAAAAA;
  localparam logic [LW-1:0] LINE_C = 25'h1234567;
  localparam logic [LW-1:0] LINE_D = 25'h00F0F0F;
  localparam logic [LW-1:0] LINE_E = 25'h1FFFFFF;
  localparam logic [LW-1:0] LINE_F = 25'h0C3A5E1;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  line_input_buffer_if #(.LINE_W(LW)) bus_if ();

  line_input_buffer #(
    .LINE_W (LW),
    .DEPTH  (2),
    .CNT_W  (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Bit k of the serial stream for line d; index LW is the even-parity bit.
  function automatic logic bit_of(input logic [LW-1:0] d, input int k);
    if (k < LW) return d[k];
    return ^d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream bits [from, to) of line d, one per clock.
  task automatic send_bits(input logic [LW-1:0] d, input int from, input int to);
    for (int k = from; k < to; k++) begin
      bus_if.bit_in    = bit_of(d, k);
      bus_if.bit_valid = 1'b1;
      step();
    end
    bus_if.bit_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    flush             = 1'b0;
    bus_if.bit_in     = 1'b0;
    bus_if.bit_valid  = 1'b0;
    bus_if.line_ready = 1'b0;

    // Reset state
    #12;
    check_val("rst_line_valid", 32'(bus_if.line_valid), 32'd0);
    check_val("rst_occupancy",  32'(bus_if.occupancy),  32'd0);
    check_val("rst_line",       32'(bus_if.line),       32'd0);
    check_val("rst_parity_err", 32'(bus_if.parity_err), 32'd0);
    rst = 1'b0;
    step();
    check_val("rst_bit_ready",  32'(bus_if.bit_ready),  32'd1);

    // First line, visible right after the completing edge
    send_bits(LINE_A, 0, NBITS);
    check_val("t1_line_valid", 32'(bus_if.line_valid), 32'd1);
    check_val("t1_line",       32'(bus_if.line),       32'h1555555);
    check_val("t1_occupancy",  32'(bus_if.occupancy),  32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("t1_flush_occ", 32'(bus_if.occupancy), 32'd0);

    // Fill to full, back-pressure on the completing bit
    send_bits(LINE_A, 0, NBITS);
    send_bits(LINE_B, 0, NBITS);
    check_val("t2_occ_full", 32'(bus_if.occupancy), 32'd2);
    send_bits(LINE_C, 0, NBITS - 1);
    check_val("t2_ready_low", 32'(bus_if.bit_ready), 32'd0);
    // Completing bit offered together with a pop: pop happens, bit is held off
    bus_if.bit_in     = bit_of(LINE_C, NBITS - 1);
    bus_if.bit_valid  = 1'b1;
    bus_if.line_ready = 1'b1;
    step();
    bus_if.line_ready = 1'b0;
    bus_if.bit_valid  = 1'b0;
    check_val("t2_occ_after_pop", 32'(bus_if.occupancy), 32'd1);
    check_val("t2_head_b",        32'(bus_if.line),      32'h0AAAAAA);
    check_val("t2_ready_high",    32'(bus_if.bit_ready), 32'd1);
    send_bits(LINE_C, NBITS - 1, NBITS);
    check_val("t2_occ_c_pushed", 32'(bus_if.occupancy), 32'd2);
    check_val("t2_head_still_b", 32'(bus_if.line),      32'h0AAAAAA);
    bus_if.line_ready = 1'b1;
    step();
    bus_if.line_ready = 1'b0;
    check_val("t2_head_c", 32'(bus_if.line),      32'h1234567);
    check_val("t2_occ_1",  32'(bus_if.occupancy), 32'd1);

    // Simultaneous push and pop at occupancy 1
    send_bits(LINE_D, 0, NBITS - 1);
    bus_if.bit_in     = bit_of(LINE_D, NBITS - 1);
    bus_if.bit_valid  = 1'b1;
    bus_if.line_ready = 1'b1;
    step();
    bus_if.bit_valid  = 1'b0;
    bus_if.line_ready = 1'b0;
    check_val("t3_occ_same", 32'(bus_if.occupancy), 32'd1);
    check_val("t3_head_d",   32'(bus_if.line),      32'h00F0F0F);

    // Flush mid-line with a line queued; same-cycle bit and pop are discarded
    send_bits(LINE_E, 0, 12);
    flush             = 1'b1;
    bus_if.bit_in     = 1'b1;
    bus_if.bit_valid  = 1'b1;
    bus_if.line_ready = 1'b1;
    step();
    flush             = 1'b0;
    bus_if.bit_valid  = 1'b0;
    bus_if.line_ready = 1'b0;
    check_val("t4_occ",        32'(bus_if.occupancy),  32'd0);
    check_val("t4_line_valid", 32'(bus_if.line_valid), 32'd0);
    send_bits(LINE_F, 0, NBITS);
    check_val("t4_fresh_line", 32'(bus_if.line),      32'h0C3A5E1);
    check_val("t4_fresh_occ",  32'(bus_if.occupancy), 32'd1);

    // Asynchronous reset in the middle of a line
    send_bits(LINE_A, 0, 7);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_async_valid", 32'(bus_if.line_valid), 32'd0);
    check_val("t5_async_occ",   32'(bus_if.occupancy),  32'd0);
    check_val("t5_async_line",  32'(bus_if.line),       32'd0);
    #1;
    rst = 1'b0;
    step();
    send_bits(LINE_B, 0, NBITS - 1);
    check_val("t5_no_push",       32'(bus_if.occupancy),  32'd0);
    check_val("t5_no_push_valid", 32'(bus_if.line_valid), 32'd0);
    send_bits(LINE_B, NBITS - 1, NBITS);
    check_val("t5_line_after", 32'(bus_if.line),      32'h0AAAAAA);
    check_val("t5_occ_after",  32'(bus_if.occupancy), 32'd1);

`ifdef LINE_PARITY_CHECK_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    // 25'h1 with parity bit 1 is even overall -> pushed
    send_bits(25'h0000001, 0, NBITS);
    check_val("t6_par_ok_occ", 32'(bus_if.occupancy),  32'd1);
    check_val("t6_par_ok_err", 32'(bus_if.parity_err), 32'd0);
    // Same data with parity bit 0 -> dropped, one error pulse
    send_bits(25'h0000001, 0, LW);
    bus_if.bit_in    = 1'b0;
    bus_if.bit_valid = 1'b1;
    step();
    bus_if.bit_valid = 1'b0;
    check_val("t6_par_bad_err", 32'(bus_if.parity_err), 32'd1);
    check_val("t6_par_bad_occ", 32'(bus_if.occupancy),  32'd1);
    step();
    check_val("t6_par_err_pulse", 32'(bus_if.parity_err), 32'd0);
`else
    check_val("t6_parity_tied", 32'(bus_if.parity_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
